// File: rtl/reg_bank_arbiter_if.sv
// Requester-side command bus for reg_bank_arbiter: two req/gnt/ack ports
// sharing one read-data return and a busy flag.
interface reg_bank_arbiter_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) ();
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [WIDTH-1:0]  din0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [WIDTH-1:0]  din1;
    logic              gnt0;
    logic              gnt1;
    logic              ack0;
    logic              ack1;
    logic [WIDTH-1:0]  dout;
    logic              busy;

    modport master (
        output req0, we0, addr0, din0, req1, we1, addr1, din1,
        input  gnt0, gnt1, ack0, ack1, dout, busy
    );

    modport slave (
        input  req0, we0, addr0, din0, req1, we1, addr1, din1,
        output gnt0, gnt1, ack0, ack1, dout, busy
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter that serialises single-word read/write commands from
// two requesters onto an internal bank of 2**ADDR_W load-enabled registers.
module reg_bank_arbiter #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    reg_bank_arbiter_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t            state, state_next;
    logic              last_served;
    logic              winner, win_next, take;
    logic              ereq0, ereq1;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [WIDTH-1:0]  cmd_din;
    logic              gnt0, gnt1, ack0, ack1;
    logic [WIDTH-1:0]  dout;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]  load_en;

    // A requester is masked during its own ack cycle so a held req cannot
    // be re-granted on the same edge that retires its previous command.
    assign ereq0 = bus.req0 & ~ack0;
    assign ereq1 = bus.req1 & ~ack1;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        win_next   = winner;
        case (state)
            IDLE: begin
                if (ereq0 || ereq1) begin
                    take       = 1'b1;
                    state_next = EXEC;
                    win_next   = (ereq0 && ereq1) ? ~last_served : ereq1;
                end
            end
            EXEC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_en = '0;
        if (state == EXEC && cmd_we) load_en[cmd_addr] = 1'b1;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the edge, independent of block order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_served <= 1'b1;
            winner      <= 1'b0;
            cmd_we      <= 1'b0;
            cmd_addr    <= '0;
            cmd_din     <= '0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            dout        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (take) begin
                        winner   <= win_next;
                        cmd_we   <= win_next ? bus.we1   : bus.we0;
                        cmd_addr <= win_next ? bus.addr1 : bus.addr0;
                        cmd_din  <= win_next ? bus.din1  : bus.din0;
                        gnt0     <= ~win_next;
                        gnt1     <= win_next;
                    end
                end
                EXEC: begin
                    gnt0        <= 1'b0;
                    gnt1        <= 1'b0;
                    ack0        <= ~winner;
                    ack1        <= winner;
                    last_served <= winner;
                    if (!cmd_we) dout <= mem[cmd_addr];
                end
                default: ;
            endcase
        end
    end

    // NOTE: the bank is cleared on reset because the requesters rely on every
    // word reading as zero afterwards; this costs a reset net on each bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (load_en[i]) mem[i] <= cmd_din;
            end
        end
    end

    assign bus.gnt0 = gnt0;
    assign bus.gnt1 = gnt1;
    assign bus.ack0 = ack0;
    assign bus.ack1 = ack1;
    assign bus.dout = dout;
    assign bus.busy = (state == EXEC);
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scenario bench for reg_bank_arbiter: a bank model feeds a queue of expected
// acks that a negedge monitor retires in order.
module tb_reg_bank_arbiter;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    reg_bank_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    reg_bank_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic             port;
        logic             rd;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] model_mem [2**ADDR_W];
    int               tests_run = 0;
    int               fails     = 0;

    task automatic expect_cmd(input logic port, input logic we,
                              input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] din);
        exp_t e;
        e.port = port;
        e.rd   = ~we;
        e.data = we ? '0 : model_mem[addr];
        if (we) model_mem[addr] = din;
        sb.push_back(e);
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] din);
        if (port) begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.din1 = din;
        end else begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.din0 = din;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2**ADDR_W; i++) model_mem[i] = '0;
    endtask

    // One command on an idle arbiter: gnt after one edge, ack after two.
    task automatic do_cmd(input logic port, input logic we,
                          input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] din);
        logic [WIDTH-1:0] d0;
        bit done;
        @(negedge CLK);
        d0 = bus.dout;
        expect_cmd(port, we, addr, din);
        drive(port, 1'b1, we, addr, din);
        done = 0;
        for (int k = 1; k <= 10 && !done; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                tests_run++;
                if ((port ? bus.gnt1 : bus.gnt0) !== 1'b1) begin
                    fails++;
                    $display("FAIL cmd_gnt port%0d: gnt=%b, required 1", port, port ? bus.gnt1 : bus.gnt0);
                end
            end
            if (we) begin
                tests_run++;
                if (bus.dout !== d0) begin
                    fails++;
                    $display("FAIL write_dout_hold port%0d: dout=%h, required %h", port, bus.dout, d0);
                end
            end
            if (port ? bus.ack1 : bus.ack0) begin
                done = 1;
                tests_run++;
                if (k != 2) begin
                    fails++;
                    $display("FAIL cmd_latency port%0d: ack after %0d cycles, required 2", port, k);
                end
            end
        end
        drive(port, 1'b0, 1'b0, '0, '0);
        if (!done) begin
            tests_run++;
            fails++;
            $display("FAIL cmd_timeout port%0d: no ack within 10 cycles, required ack", port);
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        sb.delete();
        clear_model();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!RST) begin
            tests_run++;
            if ((bus.gnt0 && bus.gnt1) || (bus.ack0 && bus.ack1) ||
                (bus.gnt0 && bus.ack0) || (bus.gnt1 && bus.ack1)) begin
                fails++;
                $display("FAIL exclusivity: gnt=%b%b ack=%b%b, required at most one active",
                         bus.gnt1, bus.gnt0, bus.ack1, bus.ack0);
            end
            if (bus.ack0 || bus.ack1) begin
                tests_run++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_ack: ack=%b%b, required none", bus.ack1, bus.ack0);
                end else begin
                    e = sb.pop_front();
                    if (bus.ack1 !== e.port || (e.rd && bus.dout !== e.data)) begin
                        fails++;
                        $display("FAIL scoreboard: ack port%0d dout=%h, required port%0d dout=%h",
                                 bus.ack1, bus.dout, e.port, e.rd ? e.data : bus.dout);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        tests_run++;
        if ({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.busy} !== 5'b0 || bus.dout !== '0) begin
            fails++;
            $display("FAIL reset_state: gnt/ack/busy=%b dout=%h, required 0/0",
                     {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.busy}, bus.dout);
        end
        RST = 1'b0;
        do_cmd(1'b0, 1'b1, 3'd6, 16'h5A5A);
        do_cmd(1'b0, 1'b0, 3'd6, '0);
        @(negedge CLK);
        drive(1'b0, 1'b1, 1'b1, 3'd2, 16'h1234);
        @(negedge CLK);
        tests_run++;
        if (bus.gnt0 !== 1'b1 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_exec_entry: gnt0=%b busy=%b, required 1 1", bus.gnt0, bus.busy);
        end
        RST = 1'b1;
        #1;
        tests_run++;
        if ({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.busy} !== 5'b0 || bus.dout !== '0) begin
            fails++;
            $display("FAIL reset_mid_exec: gnt/ack/busy=%b dout=%h, required 0/0",
                     {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.busy}, bus.dout);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        clear_model();
        @(negedge CLK);
        RST = 1'b0;
        do_cmd(1'b0, 1'b0, 3'd2, '0);
        do_cmd(1'b1, 1'b0, 3'd6, '0);
    endtask

    task automatic test_single_port();
        do_cmd(1'b0, 1'b1, 3'd3, 16'hBEEF);
        do_cmd(1'b0, 1'b0, 3'd3, '0);
        do_cmd(1'b0, 1'b0, 3'd2, '0);
    endtask

    task automatic test_tie();
        logic [3:0] exp_v;
        apply_reset();
        @(negedge CLK);
        expect_cmd(1'b0, 1'b1, 3'd1, 16'h00AA);
        expect_cmd(1'b1, 1'b1, 3'd1, 16'h0055);
        drive(1'b0, 1'b1, 1'b1, 3'd1, 16'h00AA);
        drive(1'b1, 1'b1, 1'b1, 3'd1, 16'h0055);
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            exp_v = {k == 1, k == 3, k == 2, k == 4};
            tests_run++;
            if ({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1} !== exp_v) begin
                fails++;
                $display("FAIL tie_order edge%0d: gnt0 gnt1 ack0 ack1=%b, required %b",
                         k, {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1}, exp_v);
            end
            if (bus.ack0) drive(1'b0, 1'b0, 1'b0, '0, '0);
            if (bus.ack1) drive(1'b1, 1'b0, 1'b0, '0, '0);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        do_cmd(1'b0, 1'b0, 3'd1, '0);
    endtask

    task automatic test_fairness();
        logic [1:0] exp_g;
        do_cmd(1'b0, 1'b1, 3'd6, 16'h0606);
        do_cmd(1'b1, 1'b1, 3'd7, 16'h0707);
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            expect_cmd(1'b0, 1'b0, 3'd6, '0);
            expect_cmd(1'b1, 1'b0, 3'd7, '0);
        end
        drive(1'b0, 1'b1, 1'b0, 3'd6, '0);
        drive(1'b1, 1'b1, 1'b0, 3'd7, '0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            exp_g = {k % 4 == 1, k % 4 == 3};
            tests_run++;
            if ({bus.gnt0, bus.gnt1} !== exp_g) begin
                fails++;
                $display("FAIL fairness edge%0d: gnt0 gnt1=%b, required %b", k, {bus.gnt0, bus.gnt1}, exp_g);
            end
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_hold_mask();
        @(negedge CLK);
        for (int i = 0; i < 3; i++) expect_cmd(1'b1, 1'b0, 3'd5, '0);
        drive(1'b1, 1'b1, 1'b0, 3'd5, '0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            tests_run++;
            if (bus.busy !== (k % 3 == 1) || bus.ack1 !== (k % 3 == 2)) begin
                fails++;
                $display("FAIL hold_mask edge%0d: busy=%b ack1=%b, required %b %b",
                         k, bus.busy, bus.ack1, k % 3 == 1, k % 3 == 2);
            end
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_dout_hold();
        do_cmd(1'b0, 1'b1, 3'd3, 16'hBEEF);
        do_cmd(1'b0, 1'b0, 3'd3, '0);
        do_cmd(1'b1, 1'b1, 3'd4, 16'h0F0F);
        tests_run++;
        if (bus.dout !== 16'hBEEF) begin
            fails++;
            $display("FAIL dout_hold: dout=%h, required beef", bus.dout);
        end
        do_cmd(1'b1, 1'b0, 3'd4, '0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        clear_model();
        test_reset();
        test_single_port();
        test_tie();
        test_fairness();
        test_hold_mask();
        test_dout_hold();
        repeat (3) @(negedge CLK);
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d acks outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
